// File: rtl/if_buf_pkg.sv
// Shared types and sizing helpers for the IF-stage instruction buffer.
// IF_BUF_ERR_EN adds a per-entry bus-error flag to the entry layout.
package if_buf_pkg;

  localparam int unsigned IF_BUF_MAX_OUT_W = 4;
  localparam int unsigned IF_BUF_DATA_W    = 32;

  // Canonical entry layout at the default word width; the top mirrors it at DATA_W.
  typedef struct packed {
    logic [IF_BUF_DATA_W-1:0] data;
`ifdef IF_BUF_ERR_EN
    logic                     err;
`endif
  } if_buf_entry_t;

  function automatic int unsigned if_buf_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned if_buf_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/if_buf_outstanding.sv
// Outstanding-request and post-flush discard counters, plus request credit.
module if_buf_outstanding
  import if_buf_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned CNT_W   = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             gnt_i,
  input  logic             rvalid_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             credit_o,
  output logic             discarding_o
);

  localparam int unsigned SUM_W = IF_BUF_MAX_OUT_W + CNT_W;

  logic [IF_BUF_MAX_OUT_W-1:0] outstanding_q, outstanding_d;
  logic [IF_BUF_MAX_OUT_W-1:0] discard_q, discard_d;
  logic [SUM_W-1:0]            occupancy;

  always_comb begin
    outstanding_d = outstanding_q;
    if (gnt_i && !rvalid_i) begin
      outstanding_d = outstanding_q + IF_BUF_MAX_OUT_W'(1);
    end else if (!gnt_i && rvalid_i) begin
      outstanding_d = outstanding_q - IF_BUF_MAX_OUT_W'(1);
    end

    // A grant in the flush cycle belongs to the new stream, so only the old
    // outstanding count (less any response arriving now) is discarded.
    discard_d = discard_q;
    if (flush_i) begin
      discard_d = (rvalid_i && outstanding_q != '0) ?
                  outstanding_q - IF_BUF_MAX_OUT_W'(1) : outstanding_q;
    end else if (rvalid_i && discard_q != '0) begin
      discard_d = discard_q - IF_BUF_MAX_OUT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  assign occupancy    = SUM_W'(outstanding_q) + SUM_W'(count_i);
  assign credit_o     = (occupancy < SUM_W'(DEPTH)) &&
                        (outstanding_q < IF_BUF_MAX_OUT_W'(MAX_OUT));
  assign discarding_o = discard_q != '0;

endmodule

// File: rtl/if_stage_buf.sv
// IF-stage instruction capture buffer: memory responses in, fetch words out.
// Define IF_BUF_ERR_EN to store mem_err_i per entry and drive fetch_err_o.
module if_stage_buf
  import if_buf_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  logic                            mem_gnt_i,
  input  logic                            mem_rvalid_i,
  input  logic [DATA_W-1:0]               mem_rdata_i,
  input  logic                            mem_err_i,
  output logic                            credit_o,
  output logic                            fetch_valid_o,
  output logic [DATA_W-1:0]               fetch_rdata_o,
  output logic                            fetch_err_o,
  input  logic                            fetch_ready_i,
  output logic [if_buf_cnt_w(DEPTH)-1:0]  count_o
);

  localparam int unsigned PTR_W = if_buf_ptr_w(DEPTH);
  localparam int unsigned CNT_W = if_buf_cnt_w(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
`ifdef IF_BUF_ERR_EN
    logic              err;
`endif
  } entry_t;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           mem_q [DEPTH];
  entry_t           wr_entry, head;
  logic             discarding, push_req, push, pop, full;

  assign full          = count_q == CNT_W'(DEPTH);
  assign fetch_valid_o = count_q != '0;
  assign pop           = fetch_valid_o && fetch_ready_i && !flush_i;
  assign push_req      = mem_rvalid_i && !discarding && !flush_i;
  assign push          = push_req && (!full || pop);

  always_comb begin
    wr_entry      = '0;
    wr_entry.data = mem_rdata_i;
`ifdef IF_BUF_ERR_EN
    wr_entry.err  = mem_err_i;
`endif
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Head is gated by valid so stale storage never leaks out after reset/flush.
  assign head          = mem_q[rd_ptr_q];
  assign fetch_rdata_o = fetch_valid_o ? head.data : '0;
`ifdef IF_BUF_ERR_EN
  assign fetch_err_o   = fetch_valid_o && head.err;
`else
  logic unused_err;
  assign unused_err    = mem_err_i;
  assign fetch_err_o   = 1'b0;
`endif
  assign count_o       = count_q;

  if_buf_outstanding #(
    .DEPTH   (DEPTH),
    .MAX_OUT (MAX_OUT),
    .CNT_W   (CNT_W)
  ) u_outstanding (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .gnt_i        (mem_gnt_i),
    .rvalid_i     (mem_rvalid_i),
    .count_i      (count_q),
    .credit_o     (credit_o),
    .discarding_o (discarding)
  );

`ifndef SYNTHESIS
  overflow_chk: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_req && full && !pop))
    else $error("if_stage_buf: response dropped, buffer full without pop");
`endif

endmodule

// File: tb/tb_if_stage_buf.sv
// Directed scoreboard bench for if_stage_buf (DEPTH=4, MAX_OUT=4, DATA_W=32).
module tb_if_stage_buf;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
  logic        credit_o;
  logic        fetch_valid_o;
  logic [31:0] fetch_rdata_o;
  logic        fetch_err_o;
  logic        fetch_ready_i;
  logic [2:0]  count_o;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

`ifdef IF_BUF_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  if_stage_buf #(
    .DATA_W  (32),
    .DEPTH   (4),
    .MAX_OUT (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .mem_err_i     (mem_err_i),
    .credit_o      (credit_o),
    .fetch_valid_o (fetch_valid_o),
    .fetch_rdata_o (fetch_rdata_o),
    .fetch_err_o   (fetch_err_o),
    .fetch_ready_i (fetch_ready_i),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    sb.push_back(x);
  endtask

  // Compares any handshake that completes at the coming edge, then advances.
  task automatic cycle();
    exp_t x;
    if (fetch_valid_o && fetch_ready_i && !flush_i) begin
      check("pop_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        x = sb.pop_front();
        check("pop_data", 64'(fetch_rdata_o), 64'(x.data));
        check("pop_err", 64'(fetch_err_o), 64'(x.err));
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    mem_rdata_i = '0; mem_err_i = 1'b0; fetch_ready_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #1;
    check("rst_valid", 64'(fetch_valid_o), 64'd0);
    check("rst_rdata", 64'(fetch_rdata_o), 64'd0);
    check("rst_err",   64'(fetch_err_o),   64'd0);
    check("rst_count", 64'(count_o),       64'd0);
    check("rst_credit", 64'(credit_o),     64'd1);
    rst_i = 1'b0;

    // Single push, one-cycle latency, popped immediately
    mem_gnt_i = 1'b1; cycle(); mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0013; push_exp(32'h0000_0013, 1'b0);
    fetch_ready_i = 1'b1;
    check("t1_valid_before", 64'(fetch_valid_o), 64'd0);
    cycle(); mem_rvalid_i = 1'b0;
    check("t1_valid", 64'(fetch_valid_o), 64'd1);
    check("t1_rdata", 64'(fetch_rdata_o), 64'h13);
    check("t1_count1", 64'(count_o), 64'd1);
    cycle();
    check("t1_count0", 64'(count_o), 64'd0);
    check("t1_valid_low", 64'(fetch_valid_o), 64'd0);

    // Fill to DEPTH with ready low; credit falls after the 4th grant
    fetch_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_gnt_i = 1'b1; cycle();
      check("t2_credit", 64'(credit_o), (i < 3) ? 64'd1 : 64'd0);
    end
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA0 + 32'(i); push_exp(32'hA0 + 32'(i), 1'b0);
      cycle();
    end
    mem_rvalid_i = 1'b0;
    check("t2_count_full", 64'(count_o), 64'd4);
    check("t2_credit_full", 64'(credit_o), 64'd0);
    check("t2_head", 64'(fetch_rdata_o), 64'hA0);

    // Full buffer: simultaneous push and pop keeps count at DEPTH
    mem_gnt_i = 1'b1; cycle(); mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA4; push_exp(32'hA4, 1'b0);
    fetch_ready_i = 1'b1;
    cycle();
    mem_rvalid_i = 1'b0; fetch_ready_i = 1'b0;
    check("t3_count", 64'(count_o), 64'd4);
    check("t3_head", 64'(fetch_rdata_o), 64'hA1);
    fetch_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    fetch_ready_i = 1'b0;
    check("t3_drained", 64'(count_o), 64'd0);
    check("t3_sb_empty", 64'(sb.size()), 64'd0);
    check("t3_credit", 64'(credit_o), 64'd1);

    // Flush with buffered entry, 3 outstanding and a coincident response
    mem_gnt_i = 1'b1; cycle(); mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77; cycle(); mem_rvalid_i = 1'b0;
    check("t4_count_pre", 64'(count_o), 64'd1);
    mem_gnt_i = 1'b1; cycle(); cycle(); cycle(); mem_gnt_i = 1'b0;
    check("t4_credit_pre", 64'(credit_o), 64'd0);
    flush_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0;
    cycle();
    flush_i = 1'b0; mem_rvalid_i = 1'b0;
    check("t4_valid_flushed", 64'(fetch_valid_o), 64'd0);
    check("t4_count_flushed", 64'(count_o), 64'd0);
    check("t4_discard", 64'(dut.u_outstanding.discard_q), 64'd2);
    mem_gnt_i = 1'b1; cycle(); mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD1; cycle();
    mem_rdata_i = 32'hBAD2; cycle();
    check("t4_dropped", 64'(count_o), 64'd0);
    mem_rdata_i = 32'h55; push_exp(32'h55, 1'b0); cycle();
    mem_rvalid_i = 1'b0;
    check("t4_new_valid", 64'(fetch_valid_o), 64'd1);
    check("t4_new_rdata", 64'(fetch_rdata_o), 64'h55);
    fetch_ready_i = 1'b1; cycle(); fetch_ready_i = 1'b0;
    check("t4_count_end", 64'(count_o), 64'd0);

    // Asynchronous reset mid-stream with three entries held
    mem_gnt_i = 1'b1; cycle(); cycle(); cycle(); mem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hC0 + 32'(i); cycle();
    end
    mem_rvalid_i = 1'b0;
    check("t5_count3", 64'(count_o), 64'd3);
    #2 rst_i = 1'b1;
    #1;
    check("t5_async_valid", 64'(fetch_valid_o), 64'd0);
    check("t5_async_rdata", 64'(fetch_rdata_o), 64'd0);
    check("t5_async_count", 64'(count_o), 64'd0);
    check("t5_async_credit", 64'(credit_o), 64'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    cycle();
    check("t5_post_count", 64'(count_o), 64'd0);

    // Errored response
    mem_gnt_i = 1'b1; cycle(); mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; mem_err_i = 1'b1;
    push_exp(32'hDEAD_BEEF, ERR_EXP);
    cycle();
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    check("t6_rdata", 64'(fetch_rdata_o), 64'hDEAD_BEEF);
    check("t6_err", 64'(fetch_err_o), 64'(ERR_EXP));
    fetch_ready_i = 1'b1; cycle(); fetch_ready_i = 1'b0;
    check("t6_err_after", 64'(fetch_err_o), 64'd0);
    check("end_sb_empty", 64'(sb.size()), 64'd0);
    check("end_count", 64'(count_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
